// File: rtl/rs_multi_cdb_pkg.sv
// Shared types and constants for the multi-CDB reservation station.
package rs_multi_cdb_pkg;

  localparam int RS_DEPTH   = 16;
  localparam int RS_NUM_CDB = 2;
  localparam int RS_TAG_W   = 5;
  localparam int RS_DATA_W  = 32;
  localparam int RS_OP_W    = 6;

  // A producer tag of zero marks an operand whose value is already present.
  localparam logic [RS_TAG_W-1:0] TAG_READY = '0;

  typedef enum logic [RS_OP_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;

  typedef logic [RS_NUM_CDB*RS_TAG_W-1:0]  cdb_tag_vec_t;
  typedef logic [RS_NUM_CDB*RS_DATA_W-1:0] cdb_data_vec_t;

  // Place a tag into channel k of a packed CDB tag bus.
  function automatic cdb_tag_vec_t cdb_put_tag(cdb_tag_vec_t v, int unsigned k,
                                               logic [RS_TAG_W-1:0] t);
    v[k*RS_TAG_W +: RS_TAG_W] = t;
    return v;
  endfunction

  // Place a value into channel k of a packed CDB data bus.
  function automatic cdb_data_vec_t cdb_put_data(cdb_data_vec_t v, int unsigned k,
                                                 logic [RS_DATA_W-1:0] d);
    v[k*RS_DATA_W +: RS_DATA_W] = d;
    return v;
  endfunction

endpackage

// File: rtl/rs_multi_cdb_if.sv
// Issue, CDB snoop and dispatch bundle of the reservation station.
interface rs_multi_cdb_if
  import rs_multi_cdb_pkg::*;
#(
  parameter int DEPTH   = RS_DEPTH,
  parameter int NUM_CDB = RS_NUM_CDB,
  parameter int TAG_W   = RS_TAG_W,
  parameter int DATA_W  = RS_DATA_W,
  parameter int OP_W    = RS_OP_W
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Issue side
  logic                      in_valid;
  logic                      in_ready;
  logic [OP_W-1:0]           in_op;
  logic [TAG_W-1:0]          in_tag;
  logic [DATA_W-1:0]         in_v1;
  logic [DATA_W-1:0]         in_v2;
  logic [TAG_W-1:0]          in_q1;
  logic [TAG_W-1:0]          in_q2;
  logic [DATA_W-1:0]         in_imm;
  logic [DATA_W-1:0]         in_pc;

  // Result broadcast channels and ROB head for age ordering
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]          rob_head;

  // Dispatch side
  logic                      out_valid;
  logic                      out_ready;
  logic [OP_W-1:0]           out_op;
  logic [TAG_W-1:0]          out_tag;
  logic [DATA_W-1:0]         out_v1;
  logic [DATA_W-1:0]         out_v2;
  logic [DATA_W-1:0]         out_imm;
  logic [DATA_W-1:0]         out_pc;
  logic [OCC_W-1:0]          occupancy;

  modport master (
    output in_valid, in_op, in_tag, in_v1, in_v2, in_q1, in_q2, in_imm, in_pc,
    input  in_ready,
    output cdb_valid, cdb_tag, cdb_data, rob_head,
    input  out_valid, out_op, out_tag, out_v1, out_v2, out_imm, out_pc,
    output out_ready,
    input  occupancy
  );

  modport slave (
    input  in_valid, in_op, in_tag, in_v1, in_v2, in_q1, in_q2, in_imm, in_pc,
    output in_ready,
    input  cdb_valid, cdb_tag, cdb_data, rob_head,
    output out_valid, out_op, out_tag, out_v1, out_v2, out_imm, out_pc,
    input  out_ready,
    output occupancy
  );

endinterface

// File: rtl/rs_age_select.sv
// Combinational picker: oldest ready entry by ROB age, lowest index on a tie.
module rs_age_select #(
  parameter  int DEPTH = 16,
  parameter  int TAG_W = 5,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]            rob_head,
  output logic [IDX_W-1:0]            idx,
  output logic                        found
);

  logic [DEPTH-1:0][TAG_W-1:0] age;
  logic [TAG_W-1:0]            best_age;

  // Distance from the ROB head; the TAG_W-wide subtraction wraps modulo 2^TAG_W.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age[i] = tags[i] - rob_head;
    end
  end

  // Upward scan with strict less-than so an equal age keeps the lower index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    idx      = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || age[i] < best_age)) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_age = age[i];
      end
    end
  end

endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station: holds renamed ALU ops, snoops NUM_CDB result channels
// for operand wakeup and dispatches the oldest ready op through an output register.
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int DEPTH   = RS_DEPTH,
  parameter int NUM_CDB = RS_NUM_CDB,
  parameter int TAG_W   = RS_TAG_W,
  parameter int DATA_W  = RS_DATA_W,
  parameter int OP_W    = RS_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  rs_multi_cdb_if.slave      bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  q1;
    logic [TAG_W-1:0]  q2;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } out_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t ins;
  out_t   out_q, out_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic                        in_ready_w, accept, load;
  logic [IDX_W-1:0]            free_idx, sel_idx;
  logic                        sel_found;
  logic [DEPTH-1:0]            ready_vec;
  logic [DEPTH-1:0][TAG_W-1:0] tag_vec;
  logic [TAG_W-1:0]            cdb_tag_a  [NUM_CDB];
  logic [DATA_W-1:0]           cdb_data_a [NUM_CDB];

  // Handshakes depend only on registered occupancy and the global enable.
  assign in_ready_w = rdy & (occ_q < OCC_W'(DEPTH));
  assign accept     = bus.in_valid & in_ready_w;
  assign load       = rdy & (~out_q.valid | bus.out_ready) & sel_found;

  // Split the packed broadcast buses into per-channel views.
  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_tag_a[k]  = bus.cdb_tag[k*TAG_W +: TAG_W];
      cdb_data_a[k] = bus.cdb_data[k*DATA_W +: DATA_W];
    end
  end

  // Ready vector and tags of registered entries feed the age picker.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = ent_q[i].busy && ent_q[i].q1 == '0 && ent_q[i].q2 == '0;
      tag_vec[i]   = ent_q[i].tag;
    end
  end

  // Lowest-index free slot, taken from registered state only.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) free_idx = IDX_W'(i);
    end
  end

  rs_age_select #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_age_select (
    .ready    (ready_vec),
    .tags     (tag_vec),
    .rob_head (bus.rob_head),
    .idx      (sel_idx),
    .found    (sel_found)
  );

  // Incoming op with same-cycle CDB capture; channels scanned downward so the lowest k lands last.
  always_comb begin
    ins = '{busy: 1'b1, op: bus.in_op, tag: bus.in_tag, q1: bus.in_q1, q2: bus.in_q2,
            v1: bus.in_v1, v2: bus.in_v2, imm: bus.in_imm, pc: bus.in_pc};
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (bus.in_q1 != '0 && bus.cdb_valid[k] && cdb_tag_a[k] == bus.in_q1) begin
        ins.v1 = cdb_data_a[k];
        ins.q1 = '0;
      end
      if (bus.in_q2 != '0 && bus.cdb_valid[k] && cdb_tag_a[k] == bus.in_q2) begin
        ins.v2 = cdb_data_a[k];
        ins.q2 = '0;
      end
    end
  end

  // Next state: flush clears everything; otherwise wakeup, dispatch and insert when enabled.
  always_comb begin
    ent_d = ent_q;
    out_d = out_q;
    occ_d = occ_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      out_d = '0;
      occ_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
          if (ent_q[i].busy && ent_q[i].q1 != '0 && bus.cdb_valid[k] &&
              cdb_tag_a[k] == ent_q[i].q1) begin
            ent_d[i].v1 = cdb_data_a[k];
            ent_d[i].q1 = '0;
          end
          if (ent_q[i].busy && ent_q[i].q2 != '0 && bus.cdb_valid[k] &&
              cdb_tag_a[k] == ent_q[i].q2) begin
            ent_d[i].v2 = cdb_data_a[k];
            ent_d[i].q2 = '0;
          end
        end
      end
      if (load) begin
        out_d = '{valid: 1'b1, op: ent_q[sel_idx].op, tag: ent_q[sel_idx].tag,
                  v1: ent_q[sel_idx].v1, v2: ent_q[sel_idx].v2,
                  imm: ent_q[sel_idx].imm, pc: ent_q[sel_idx].pc};
        ent_d[sel_idx].busy = 1'b0;
      end else if (bus.out_ready) begin
        out_d.valid = 1'b0;
      end
      if (accept) ent_d[free_idx] = ins;
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(load);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: the whole entry array is cleared on reset, not just the busy bits, so no X ever reaches the dispatch fields.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      out_q <= '0;
      occ_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      ent_q <= ent_d;
      out_q <= out_d;
      occ_q <= occ_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_q.valid;
  assign bus.out_op    = out_q.op;
  assign bus.out_tag   = out_q.tag;
  assign bus.out_v1    = out_q.v1;
  assign bus.out_v2    = out_q.v2;
  assign bus.out_imm   = out_q.imm;
  assign bus.out_pc    = out_q.pc;
  assign bus.occupancy = occ_q;

endmodule
